if_id_hazard: RTL and testbench

// - IF/ID pipeline register plus hazard control for the 5-stage RV32I core.
// - Sits directly upstream of id_ex: latches PC/instruction from fetch and presents them to decode.
// - Detects load-use hazards against the instruction in EX: stalls PC and IF/ID, and drives a bubble request that zeroes decode control signals into id_ex.
// - Flushes wrong-path instructions when EX resolves a taken branch/jump.

---
 rtl/if_id_hazard.sv | 104 ++++++++++
 tb/tb_if_id_hazard.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use stall and taken-branch flush control.
// Optional performance counters are enabled by defining IF_ID_PERF_CNT_EN.
module if_id_hazard #(
   parameter int          size     = 32,
   parameter logic [31:0] NOP_INSN = 32'h00000013
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic [size-1:0] PC_IF,
   input  logic [31:0]     instr_IF,
   input  logic            MemRead_EX,
   input  logic [4:0]      wrin_EX,
   input  logic            branch_taken_EX,
   output logic [size-1:0] PC_ID,
   output logic [31:0]     instr_ID,
   output logic            valid_ID,
   output logic            pc_hold,
   output logic            bubble_ID
`ifdef IF_ID_PERF_CNT_EN
   ,
   output logic [31:0]     stall_count,
   output logic [31:0]     flush_count
`endif
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic {RUN, STALLED} state_t;

   state_t     state_reg;
   state_t     state_next;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [6:0] opc;
   logic       uses_rs1;
   logic       uses_rs2;
   logic       hazard;
   logic       hazard_stall;

   assign rs1 = instr_ID[19:15];
   assign rs2 = instr_ID[24:20];
   assign opc = instr_ID[6:0];

   assign uses_rs1 = (opc != OPC_LUI) && (opc != OPC_AUIPC) && (opc != OPC_JAL);
   assign uses_rs2 = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);

   // x0 is never a real dependency, so wrin_EX==0 cannot stall
   assign hazard = valid_ID && MemRead_EX && (wrin_EX != 5'd0) &&
                   ((uses_rs1 && (rs1 == wrin_EX)) || (uses_rs2 && (rs2 == wrin_EX)));

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state_reg <= RUN;
      else          state_reg <= state_next;
   end

   // STALLED lasts exactly one cycle: the bubble has already pushed the load to MEM
   always_comb begin
      state_next   = RUN;
      hazard_stall = 1'b0;
      if (!branch_taken_EX && (state_reg == RUN) && hazard) begin
         state_next   = STALLED;
         hazard_stall = 1'b1;
      end
   end

   assign pc_hold   = hazard_stall;
   assign bubble_ID = hazard_stall | branch_taken_EX | !valid_ID;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         PC_ID    <= '0;
         instr_ID <= NOP_INSN;
         valid_ID <= 1'b0;
      end else if (branch_taken_EX) begin
         PC_ID    <= PC_IF;
         instr_ID <= NOP_INSN;
         valid_ID <= 1'b0;
      end else if (!hazard_stall) begin
         PC_ID    <= PC_IF;
         instr_ID <= instr_IF;
         valid_ID <= 1'b1;
      end
   end

`ifdef IF_ID_PERF_CNT_EN
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (hazard_stall && (stall_count != 32'hFFFFFFFF))
            stall_count <= stall_count + 32'd1;
         if (branch_taken_EX && (flush_count != 32'hFFFFFFFF))
            flush_count <= flush_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_id_hazard.sv
// Bench for if_id_hazard: directed vector table, reset-mid-stall sequence and
// randomized traffic checked against an instruction-level dependency model.
module tb_if_id_hazard;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic [31:0] PC_IF;
   logic [31:0] instr_IF;
   logic        MemRead_EX;
   logic [4:0]  wrin_EX;
   logic        branch_taken_EX;
   logic [31:0] PC_ID;
   logic [31:0] instr_ID;
   logic        valid_ID;
   logic        pc_hold;
   logic        bubble_ID;
`ifdef IF_ID_PERF_CNT_EN
   logic [31:0] stall_count;
   logic [31:0] flush_count;
`endif

   int tests = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   if_id_hazard dut (
      .CLK(CLK), .RESET_N(RESET_N), .PC_IF(PC_IF), .instr_IF(instr_IF),
      .MemRead_EX(MemRead_EX), .wrin_EX(wrin_EX), .branch_taken_EX(branch_taken_EX),
      .PC_ID(PC_ID), .instr_ID(instr_ID), .valid_ID(valid_ID),
      .pc_hold(pc_hold), .bubble_ID(bubble_ID)
`ifdef IF_ID_PERF_CNT_EN
      , .stall_count(stall_count), .flush_count(flush_count)
`endif
   );

   typedef struct {
      logic [31:0] pc_if;
      logic [31:0] ins_if;
      logic        mr;
      logic [4:0]  wr;
      logic        br;
      logic [31:0] e_pc;
      logic [31:0] e_ins;
      logic        e_valid;
      logic        e_hold;
      logic        e_bubble;
   } vec_t;

   vec_t vecs[13];

   // reference model state
   logic [31:0] m_pc, m_ins;
   logic        m_valid, m_stalled;
   int          m_stalls, m_flushes;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                             input logic e_valid, input logic e_hold, input logic e_bubble);
      chk({tag, ".PC_ID"}, PC_ID, e_pc);
      chk({tag, ".instr_ID"}, instr_ID, e_ins);
      chk({tag, ".valid_ID"}, {31'd0, valid_ID}, {31'd0, e_valid});
      chk({tag, ".pc_hold"}, {31'd0, pc_hold}, {31'd0, e_hold});
      chk({tag, ".bubble_ID"}, {31'd0, bubble_ID}, {31'd0, e_bubble});
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic mr,
                        input logic [4:0] wr, input logic br);
      PC_IF = pc; instr_IF = ins; MemRead_EX = mr; wrin_EX = wr; branch_taken_EX = br;
   endtask

   // Which architectural registers an instruction reads, by instruction format.
   function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
      case (ins[6:0])
         7'b0110111, 7'b0010111, 7'b1101111: return 1'b0;                 // U/J formats
         7'b0110011, 7'b0100011, 7'b1100011: return ins[19:15] == r || ins[24:20] == r;
         default:                            return ins[19:15] == r;
      endcase
   endfunction

   function automatic logic [31:0] rand_insn();
      logic [6:0] pool[10];
      logic [31:0] ins;
      pool = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
               7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};
      ins = $urandom;
      ins[6:0]   = pool[$urandom_range(0, 9)];
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      return ins;
   endfunction

   task automatic model_reset();
      m_pc = '0; m_ins = 32'h00000013; m_valid = 1'b0; m_stalled = 1'b0;
      m_stalls = 0; m_flushes = 0;
   endtask

   initial begin
      // row: pc_if, instr_if, mr, wr, br | PC_ID, instr_ID, valid, hold, bubble
      vecs[0]  = '{32'h04, 32'h00100093, 0, 5'd0, 0, 32'h00, 32'h00000013, 0, 0, 1};
      vecs[1]  = '{32'h08, 32'h00728333, 0, 5'd0, 0, 32'h04, 32'h00100093, 1, 0, 0};
      vecs[2]  = '{32'h0C, 32'h00000013, 1, 5'd5, 0, 32'h08, 32'h00728333, 1, 1, 1};
      vecs[3]  = '{32'h0C, 32'h00000013, 0, 5'd0, 0, 32'h08, 32'h00728333, 1, 0, 0};
      vecs[4]  = '{32'h10, 32'h00028337, 0, 5'd0, 0, 32'h0C, 32'h00000013, 1, 0, 0};
      vecs[5]  = '{32'h14, 32'h00128313, 1, 5'd5, 0, 32'h10, 32'h00028337, 1, 0, 0};
      vecs[6]  = '{32'h18, 32'h00000013, 1, 5'd5, 0, 32'h14, 32'h00128313, 1, 1, 1};
      vecs[7]  = '{32'h18, 32'h00000033, 1, 5'd5, 0, 32'h14, 32'h00128313, 1, 0, 0};
      vecs[8]  = '{32'h1C, 32'h00000013, 1, 5'd0, 0, 32'h18, 32'h00000033, 1, 0, 0};
      vecs[9]  = '{32'h20, 32'h00528333, 0, 5'd0, 1, 32'h1C, 32'h00000013, 1, 0, 1};
      vecs[10] = '{32'h40, 32'h00728333, 1, 5'd5, 0, 32'h20, 32'h00000013, 0, 0, 1};
      vecs[11] = '{32'h44, 32'h00000013, 1, 5'd5, 1, 32'h40, 32'h00728333, 1, 0, 1};
      vecs[12] = '{32'h48, 32'h00000013, 0, 5'd0, 0, 32'h44, 32'h00000013, 0, 0, 1};

      RESET_N = 1'b0;
      drive(32'h0, 32'h0, 0, 5'd0, 0);
      @(posedge CLK); #1;
      check_outs("reset", 32'h0, 32'h00000013, 0, 0, 1);
      RESET_N = 1'b1;

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].pc_if, vecs[i].ins_if, vecs[i].mr, vecs[i].wr, vecs[i].br);
         #3;
         $display("[TB] vec %0d pc_if=%h instr_if=%h mr=%0b wr=%0d br=%0b -> PC_ID=%h instr_ID=%h v=%0b hold=%0b bub=%0b",
                  i, PC_IF, instr_IF, MemRead_EX, wrin_EX, branch_taken_EX,
                  PC_ID, instr_ID, valid_ID, pc_hold, bubble_ID);
         check_outs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ins,
                    vecs[i].e_valid, vecs[i].e_hold, vecs[i].e_bubble);
         @(posedge CLK); #1;
      end
`ifdef IF_ID_PERF_CNT_EN
      chk("table.stall_count", stall_count, 32'd2);
      chk("table.flush_count", flush_count, 32'd2);
`endif

      // reset asserted in the middle of a load-use stall
      drive(32'h80, 32'h00728333, 0, 5'd0, 0);
      @(posedge CLK); #1;
      drive(32'h84, 32'h00000013, 1, 5'd5, 0);
      #2;
      chk("midstall.pc_hold", {31'd0, pc_hold}, 32'd1);
      RESET_N = 1'b0;
      #1;
      $display("[TB] reset mid-stall -> PC_ID=%h instr_ID=%h v=%0b hold=%0b bub=%0b",
               PC_ID, instr_ID, valid_ID, pc_hold, bubble_ID);
      check_outs("midstall_reset", 32'h0, 32'h00000013, 0, 0, 1);
`ifdef IF_ID_PERF_CNT_EN
      chk("midstall_reset.stall_count", stall_count, 32'd0);
`endif
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      model_reset();

      // randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         logic [31:0] pc, ins;
         logic mr, br, dep, stall;
         logic [4:0] wr;
         pc  = 32'($urandom_range(0, 255)) << 2;
         ins = rand_insn();
         mr  = 1'($urandom_range(0, 1));
         wr  = 5'($urandom_range(0, 7));
         br  = ($urandom_range(0, 7) == 0);
         drive(pc, ins, mr, wr, br);
         dep   = m_valid && mr && (wr != 5'd0) && reads_reg(m_ins, wr);
         stall = dep && !br && !m_stalled;
         #3;
         $display("[TB] rnd %0d instr_ID=%h mr=%0b wr=%0d br=%0b -> hold=%0b bub=%0b exp hold=%0b",
                  n, instr_ID, mr, wr, br, pc_hold, bubble_ID, stall);
         check_outs($sformatf("rnd%0d", n), m_pc, m_ins, m_valid, stall, stall | br | !m_valid);
         @(posedge CLK); #1;
         if (br) begin
            m_pc = pc; m_ins = 32'h00000013; m_valid = 1'b0; m_flushes++;
         end else if (!stall) begin
            m_pc = pc; m_ins = ins; m_valid = 1'b1;
         end
         if (stall) m_stalls++;
         m_stalled = stall;
      end
`ifdef IF_ID_PERF_CNT_EN
      chk("rnd.stall_count", stall_count, 32'(m_stalls));
      chk("rnd.flush_count", flush_count, 32'(m_flushes));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
